// File: rtl/mem_arbiter.sv
// Arbiter giving the CPU fetch port and load/store port shared access to one single-port memory.
// Build macro ARB_DATA_PRI_EN: the data port always wins simultaneous requests (default: round-robin).
module mem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a port raises req with address/data stable and holds it until its ack.
  // ack is a one-cycle pulse in RESP; req must be low by the edge that ends RESP,
  // otherwise the following IDLE cycle sees it as a fresh request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic             last_d_q, last_d_d;
  logic             cur_d_q, cur_d_d;
  logic             is_wr_q, is_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_we_q, mem_we_d;
  logic [31:0]      mem_din_q, mem_din_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             i_ack_q, i_ack_d;
  logic             d_ack_q, d_ack_d;
  logic             busy_q, busy_d;
  logic             grant_d_sel;

  always_comb begin
`ifdef ARB_DATA_PRI_EN
    grant_d_sel = d_req;
`else
    // On a conflict the port that did not win last time gets the memory.
    grant_d_sel = d_req & (~i_req | ~last_d_q);
`endif
  end

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    cur_d_d    = cur_d_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = 4'h0;
    mem_din_d  = mem_din_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          state_d  = ACCESS;
          cur_d_d  = grant_d_sel;
          last_d_d = grant_d_sel;
          cnt_d    = CNT_LOAD;
          if (grant_d_sel) begin
            mem_addr_d = d_addr;
            mem_we_d   = d_we;
            mem_din_d  = d_wdata;
            is_wr_d    = |d_we;
          end else begin
            mem_addr_d = i_addr;
            is_wr_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        // mem_we defaults to zero here, so a store strobes only in its first ACCESS cycle.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          if (!is_wr_q) begin
            if (cur_d_q) d_rdata_d = mem_dout;
            else         i_rdata_d = mem_dout;
          end
          if (cur_d_q) d_ack_d = 1'b1;
          else         i_ack_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b1;
      cur_d_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      mem_addr_q <= 32'h0;
      mem_we_q   <= 4'h0;
      mem_din_q  <= 32'h0;
      i_rdata_q  <= 32'h0;
      d_rdata_q  <= 32'h0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      cur_d_q    <= cur_d_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_din   = mem_din_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

  a_single_ack: assert property (@(posedge clk) disable iff (rst) !(i_ack_q && d_ack_q));
  a_we_first_only: assert property (@(posedge clk) disable iff (rst)
    (state_q != ACCESS) |-> (mem_we_q == 4'h0));
  a_no_fetch_write: assert property (@(posedge clk) disable iff (rst)
    (state_q == ACCESS && !cur_d_q) |-> (mem_we_q == 4'h0));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed handshake/arbitration steps, then randomized traffic
// checked against a word-array memory reference.
module tb_mem_arbiter;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;
`ifdef ARB_DATA_PRI_EN
  localparam int BOUND = 60;
`else
  localparam int BOUND = 12;
`endif

  logic        clk;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_we;
  logic        i_ack, d_ack, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;
  logic [3:0]  mem_we;
  logic [1:0]  dbg_state;

  logic        i_req3, d_req3;
  logic [31:0] i_addr3, d_addr3, d_wdata3;
  logic [3:0]  d_we3;
  logic        i_ack3, d_ack3, busy3;
  logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_din3, mem_dout3;
  logic [3:0]  mem_we3;
  logic [1:0]  dbg_state3;

  mem_arbiter #(.MEM_LATENCY(LAT1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .dbg_state(dbg_state)
  );

  mem_arbiter #(.MEM_LATENCY(LAT3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_din(mem_din3), .mem_dout(mem_dout3),
    .busy(busy3), .dbg_state(dbg_state3)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory environment ----------------
  logic [31:0] mem  [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] ref_mem [0:255];
  logic        mem_loaded = 1'b0;
  logic [31:0] prev_addr3 = 32'h0;
  int          age3_q = 0;
  int          age3_c;

  function automatic logic [31:0] init_word(input int k);
    if (k == 0)  return 32'h00500093;
    if (k == 1)  return 32'hCAFEF00D;
    if (k == 65) return 32'h11223344;
    return 32'(k + 1) * 32'h9E3779B9;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Slow memory: data is only valid once the address has been stable LAT3 cycles.
  always_comb age3_c = (mem_addr3 == prev_addr3) ? age3_q + 1 : 0;
  assign mem_dout  = mem[mem_addr[9:2]];
  assign mem_dout3 = (age3_c >= LAT3 - 1) ? mem3[mem_addr3[9:2]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 256; k++) begin
        mem[k]  <= init_word(k);
        mem3[k] <= init_word(k);
      end
      mem_loaded <= 1'b1;
    end else begin
      if (mem_we != 4'h0)  mem[mem_addr[9:2]]   <= merge(mem[mem_addr[9:2]], mem_din, mem_we);
      if (mem_we3 != 4'h0) mem3[mem_addr3[9:2]] <= merge(mem3[mem_addr3[9:2]], mem_din3, mem_we3);
    end
    prev_addr3 <= mem_addr3;
    age3_q     <= (age3_c > 64) ? 64 : age3_c;
  end

  // ---------------- scoreboard / checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Starts at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic do_txn(input logic is_d, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output int strobes,
                        output int strobe_at, output logic [3:0] we_seen,
                        output logic [31:0] rd);
    lat = 0; strobes = 0; strobe_at = -1; we_seen = 4'h0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    while (lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (mem_we != 4'h0) begin
        strobes++; strobe_at = lat; we_seen = mem_we;
      end
      if ((is_d && d_ack) || (!is_d && i_ack)) break;
    end
    rd = is_d ? d_rdata : i_rdata;
    i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
    @(posedge clk); @(negedge clk);
    chk("ack_one_cycle", 32'(i_ack | d_ack), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  int          lat, strobes, strobe_at, k, busy_cnt;
  logic [3:0]  we_seen;
  logic [31:0] rd, d_last_read;
  logic [7:0]  got, e;
  int          i_wait, d_wait, d_strobes, d_idx;
  logic [31:0] i_exp;
  logic        d_is_wr, allow_new;

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    i_req3 = 1'b0; i_addr3 = 32'h0; d_req3 = 1'b0; d_we3 = 4'h0; d_addr3 = 32'h0; d_wdata3 = 32'h0;
    for (int j = 0; j < 256; j++) ref_mem[j] = init_word(j);
    d_last_read = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values
    chk("rst_i_ack", 32'(i_ack), 32'h0);
    chk("rst_d_ack", 32'(d_ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);

    // Instruction read of address 0
    do_txn(1'b0, 4'h0, 32'h0, 32'h0, lat, strobes, strobe_at, we_seen, rd);
    chk("i_read_lat", 32'(lat), 32'(LAT1 + 1));
    chk("i_read_data", rd, 32'h00500093);
    chk("i_read_no_we", 32'(strobes), 32'h0);

    // Full-word store, then read back
    do_txn(1'b1, 4'hf, 32'h100, 32'hDEADBEEF, lat, strobes, strobe_at, we_seen, rd);
    ref_mem[64] = merge(ref_mem[64], 32'hDEADBEEF, 4'hf);
    chk("st_lat", 32'(lat), 32'(LAT1 + 1));
    chk("st_strobes", 32'(strobes), 32'h1);
    chk("st_strobe_cycle", 32'(strobe_at), 32'h1);
    chk("st_strobe_en", 32'(we_seen), 32'hf);
    chk("st_d_rdata_kept", rd, d_last_read);
    do_txn(1'b1, 4'h0, 32'h100, 32'h0, lat, strobes, strobe_at, we_seen, rd);
    chk("ld_lat", 32'(lat), 32'(LAT1 + 1));
    chk("ld_data", rd, ref_mem[64]);
    chk("ld_no_we", 32'(strobes), 32'h0);
    d_last_read = ref_mem[64];

    // Continuous dual requests straight after reset
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    d_last_read = 32'h0;
`ifdef ARB_DATA_PRI_EN
    exp_q.push_back(8'h82); exp_q.push_back(8'h85); exp_q.push_back(8'h88); exp_q.push_back(8'h0B);
`else
    exp_q.push_back(8'h02); exp_q.push_back(8'h85); exp_q.push_back(8'h08); exp_q.push_back(8'h8B);
`endif
    i_addr = 32'h0; d_addr = 32'h100; d_we = 4'h0;
    i_req = 1'b1; d_req = 1'b1; k = 0;
    repeat (14) begin
      @(posedge clk); @(negedge clk);
      k++;
      if (i_ack) begin
        got = {1'b0, 7'(k)};
        if (exp_q.size() == 0) chk("conflict_extra_ack", 32'(got), 32'h0);
        else begin e = exp_q.pop_front(); chk("conflict_grant", 32'(got), 32'(e)); end
        chk("conflict_i_data", i_rdata, 32'h00500093);
        i_req = 1'b0;
      end else if (!i_req && k < 9) i_req = 1'b1;
      if (d_ack) begin
        got = {1'b1, 7'(k)};
        if (exp_q.size() == 0) chk("conflict_extra_ack", 32'(got), 32'h0);
        else begin e = exp_q.pop_front(); chk("conflict_grant", 32'(got), 32'(e)); end
        chk("conflict_d_data", d_rdata, ref_mem[64]);
        d_last_read = ref_mem[64];
        d_req = 1'b0;
      end else if (!d_req && k < 9) d_req = 1'b1;
    end
    chk("conflict_missing", 32'(exp_q.size()), 32'h0);
    i_req = 1'b0; d_req = 1'b0;

    // Reset in the middle of a data read
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h108;
    @(posedge clk); @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'h1);
    chk("midrst_state_before", 32'(dbg_state), 32'h1);
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_d_ack", 32'(d_ack), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_d_rdata", d_rdata, 32'h0);
    chk("midrst_i_rdata", i_rdata, 32'h0);
    chk("midrst_state", 32'(dbg_state), 32'h0);
    rst = 1'b0;
    d_last_read = 32'h0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("midrst_no_late_ack", 32'(d_ack), 32'h0);
    end
    do_txn(1'b0, 4'h0, 32'h0, 32'h0, lat, strobes, strobe_at, we_seen, rd);
    chk("midrst_i_lat", 32'(lat), 32'(LAT1 + 1));
    chk("midrst_i_data", rd, 32'h00500093);

    // Partial-byte store, then read back
    do_txn(1'b1, 4'b0011, 32'h104, 32'hAABBCCDD, lat, strobes, strobe_at, we_seen, rd);
    ref_mem[65] = merge(ref_mem[65], 32'hAABBCCDD, 4'b0011);
    chk("pst_strobes", 32'(strobes), 32'h1);
    chk("pst_strobe_en", 32'(we_seen), 32'h3);
    chk("pst_d_rdata_kept", rd, d_last_read);
    do_txn(1'b1, 4'h0, 32'h104, 32'h0, lat, strobes, strobe_at, we_seen, rd);
    chk("pst_readback", rd, 32'h1122CCDD);
    d_last_read = 32'h1122CCDD;

    // Three-cycle memory latency on the second instance
    i_req3 = 1'b1; i_addr3 = 32'h4; lat = 0; busy_cnt = 0;
    while (lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (busy3) busy_cnt++;
      if (i_ack3) break;
    end
    chk("lat3_ack_cycle", 32'(lat), 32'(LAT3 + 1));
    chk("lat3_busy_cycles", 32'(busy_cnt), 32'(LAT3 + 1));
    chk("lat3_data", i_rdata3, 32'hCAFEF00D);
    i_req3 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("lat3_busy_after", 32'(busy3), 32'h0);

    // Randomized traffic on both ports
    i_wait = 0; d_wait = 0; d_strobes = 0; d_idx = 64; i_exp = 32'h0; d_is_wr = 1'b0;
    for (int cyc = 0; cyc < 480; cyc++) begin
      allow_new = (cyc < 400);
      @(posedge clk); @(negedge clk);
      if (mem_we != 4'h0) begin
        d_strobes++;
        chk("rnd_strobe_en", 32'(mem_we), 32'(d_req ? d_we : 4'h0));
      end
      chk("rnd_dual_ack", 32'(i_ack & d_ack), 32'h0);

      if (i_req) begin
        i_wait++;
        if (i_ack) begin
          chk("rnd_i_rdata", i_rdata, i_exp);
          i_req = 1'b0;
        end else if (i_wait > BOUND) begin
          chk("rnd_i_timeout", 32'(i_wait), 32'(BOUND));
          i_req = 1'b0;
        end
      end else begin
        chk("rnd_i_spurious_ack", 32'(i_ack), 32'h0);
        if (allow_new && $urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 63);
          i_addr = {22'h0, 8'(k), 2'b00};
          i_exp = ref_mem[k];
          i_wait = 0;
          i_req = 1'b1;
        end
      end

      if (d_req) begin
        d_wait++;
        if (d_ack) begin
          if (d_is_wr) begin
            chk("rnd_st_strobes", 32'(d_strobes), 32'h1);
            chk("rnd_st_d_rdata_kept", d_rdata, d_last_read);
            ref_mem[d_idx] = merge(ref_mem[d_idx], d_wdata, d_we);
          end else begin
            chk("rnd_ld_strobes", 32'(d_strobes), 32'h0);
            chk("rnd_ld_data", d_rdata, ref_mem[d_idx]);
            d_last_read = ref_mem[d_idx];
          end
          d_req = 1'b0; d_we = 4'h0;
        end else if (d_wait > BOUND) begin
          chk("rnd_d_timeout", 32'(d_wait), 32'(BOUND));
          d_req = 1'b0; d_we = 4'h0;
        end
      end else begin
        chk("rnd_d_spurious_ack", 32'(d_ack), 32'h0);
        if (allow_new && $urandom_range(0, 2) == 0) begin
          d_idx = 64 + $urandom_range(0, 63);
          d_addr = {22'h0, 8'(d_idx), 2'b00};
          d_we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          d_wdata = $urandom;
          d_is_wr = (d_we != 4'h0);
          d_strobes = 0;
          d_wait = 0;
          d_req = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
